// File: rtl/iagu_dot_multi.sv
// Address generator for dot-product jobs: issues paired operand reads across two
// buffers (dual, same-buffer or square mode) and flags operand arrival at the PE.
module iagu_dot_multi #(
    parameter int ADDR_W   = 12,
    parameter int LEN_W    = 8,
    parameter int ROW_W    = 8,
    parameter int STRIDE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [1:0]          i_mode,
    input  logic [ADDR_W:0]     i_base_a,
    input  logic [ADDR_W:0]     i_base_b,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [ROW_W-1:0]    i_rows,
    input  logic [STRIDE_W-1:0] i_stride_a,
    input  logic [STRIDE_W-1:0] i_stride_b,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ren0,
    output logic [ADDR_W-1:0]   o_raddr0,
    output logic                o_ren1,
    output logic [ADDR_W-1:0]   o_raddr1,
    output logic                o_pe_valid,
    output logic                o_pe_last
);

    typedef enum logic [1:0] {IDLE, RUN, PHASE_B, DONE} stateT;

    localparam logic [1:0] MODE_DUAL   = 2'd0;
    localparam logic [1:0] MODE_SAME   = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;

    stateT                stateReg, stateNext;
    logic [1:0]           modeReg, modeNext;
    logic                 selAReg, selANext, selBReg, selBNext;
    logic [LEN_W-1:0]     lenReg, lenNext, elemReg, elemNext;
    logic [ROW_W-1:0]     rowsReg, rowsNext, rowReg, rowNext;
    logic [STRIDE_W-1:0]  strideAReg, strideANext, strideBReg, strideBNext;
    logic [ADDR_W-1:0]    rowStartAReg, rowStartANext, rowStartBReg, rowStartBNext;
    logic [ADDR_W-1:0]    addrAReg, addrANext, addrBReg, addrBNext;

    logic                 busyNext, doneNext, peValidNext, peLastNext;
    logic                 ren0Next, ren1Next;
    logic [ADDR_W-1:0]    raddr0Next, raddr1Next;
    logic                 doAdvance, lastElem, lastRow, readA, readB;
    logic [ADDR_W-1:0]    nextRowA, nextRowB;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stateReg     <= IDLE;
            modeReg      <= '0;
            selAReg      <= 1'b0;
            selBReg      <= 1'b0;
            lenReg       <= '0;
            elemReg      <= '0;
            rowsReg      <= '0;
            rowReg       <= '0;
            strideAReg   <= '0;
            strideBReg   <= '0;
            rowStartAReg <= '0;
            rowStartBReg <= '0;
            addrAReg     <= '0;
            addrBReg     <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_ren0       <= 1'b0;
            o_raddr0     <= '0;
            o_ren1       <= 1'b0;
            o_raddr1     <= '0;
            o_pe_valid   <= 1'b0;
            o_pe_last    <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            modeReg      <= modeNext;
            selAReg      <= selANext;
            selBReg      <= selBNext;
            lenReg       <= lenNext;
            elemReg      <= elemNext;
            rowsReg      <= rowsNext;
            rowReg       <= rowNext;
            strideAReg   <= strideANext;
            strideBReg   <= strideBNext;
            rowStartAReg <= rowStartANext;
            rowStartBReg <= rowStartBNext;
            addrAReg     <= addrANext;
            addrBReg     <= addrBNext;
            o_busy       <= busyNext;
            o_done       <= doneNext;
            o_ren0       <= ren0Next;
            o_raddr0     <= raddr0Next;
            o_ren1       <= ren1Next;
            o_raddr1     <= raddr1Next;
            o_pe_valid   <= peValidNext;
            o_pe_last    <= peLastNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        modeNext      = modeReg;
        selANext      = selAReg;
        selBNext      = selBReg;
        lenNext       = lenReg;
        elemNext      = elemReg;
        rowsNext      = rowsReg;
        rowNext       = rowReg;
        strideANext   = strideAReg;
        strideBNext   = strideBReg;
        rowStartANext = rowStartAReg;
        rowStartBNext = rowStartBReg;
        addrANext     = addrAReg;
        addrBNext     = addrBReg;
        doneNext      = 1'b0;
        peValidNext   = 1'b0;
        peLastNext    = 1'b0;
        doAdvance     = 1'b0;
        lastElem      = (elemReg == lenReg - LEN_W'(1));
        lastRow       = (rowReg == rowsReg - ROW_W'(1));
        nextRowA      = rowStartAReg + ADDR_W'(strideAReg);
        nextRowB      = rowStartBReg + ADDR_W'(strideBReg);

        case (stateReg)
            IDLE: begin
                if (i_start) begin
                    case (i_mode)
                        2'd1:    modeNext = MODE_SAME;
                        2'd2:    modeNext = MODE_SQUARE;
                        default: modeNext = (i_base_a[ADDR_W] == i_base_b[ADDR_W]) ? MODE_SAME : MODE_DUAL;
                    endcase
                    selANext      = i_base_a[ADDR_W];
                    selBNext      = i_base_b[ADDR_W];
                    lenNext       = i_len;
                    rowsNext      = i_rows;
                    strideANext   = i_stride_a;
                    strideBNext   = i_stride_b;
                    elemNext      = '0;
                    rowNext       = '0;
                    rowStartANext = i_base_a[ADDR_W-1:0];
                    rowStartBNext = i_base_b[ADDR_W-1:0];
                    addrANext     = i_base_a[ADDR_W-1:0];
                    addrBNext     = i_base_b[ADDR_W-1:0];
                    if (i_len == '0 || i_rows == '0) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                if (modeReg == MODE_SAME) stateNext = PHASE_B;
                else                      doAdvance = 1'b1;
            end
            PHASE_B: doAdvance = 1'b1;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // The read in flight completes an element: flag it and step to the next one.
        if (doAdvance) begin
            peValidNext = 1'b1;
            peLastNext  = lastElem;
            if (lastElem && lastRow) begin
                stateNext = DONE;
                doneNext  = 1'b1;
            end else begin
                stateNext = RUN;
                if (lastElem) begin
                    elemNext      = '0;
                    rowNext       = rowReg + ROW_W'(1);
                    rowStartANext = nextRowA;
                    rowStartBNext = nextRowB;
                    addrANext     = nextRowA;
                    addrBNext     = nextRowB;
                end else begin
                    elemNext  = elemReg + LEN_W'(1);
                    addrANext = addrAReg + ADDR_W'(1);
                    addrBNext = addrBReg + ADDR_W'(1);
                end
            end
        end

        if (i_abort) begin
            stateNext   = IDLE;
            doneNext    = 1'b0;
            peValidNext = 1'b0;
            peLastNext  = 1'b0;
        end

        busyNext = (stateNext != IDLE);

        // Read ports follow the state being entered, so addresses leave a flop.
        readA      = (stateNext == RUN);
        readB      = (stateNext == PHASE_B) || (stateNext == RUN && modeNext == MODE_DUAL);
        ren0Next   = 1'b0;
        ren1Next   = 1'b0;
        raddr0Next = '0;
        raddr1Next = '0;
        if (readA) begin
            if (selANext) begin
                ren1Next   = 1'b1;
                raddr1Next = addrANext;
            end else begin
                ren0Next   = 1'b1;
                raddr0Next = addrANext;
            end
        end
        if (readB) begin
            if (selBNext) begin
                ren1Next   = 1'b1;
                raddr1Next = addrBNext;
            end else begin
                ren0Next   = 1'b1;
                raddr0Next = addrBNext;
            end
        end
    end

endmodule

// File: doc/iagu_dot_multi.md
IAGU_DOT_MULTI -- requirements
Module: iagu_dot_multi

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the buffer word-address width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the vector-length field.
REQ-003 SHALL have parameter ROW_W, default 8, meaning the width of the row-count field.
REQ-004 SHALL have parameter STRIDE_W, default 8, meaning the width of the row-stride fields.
REQ-005 SHALL have port i_clk  input  1  clock, rising-edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  one-cycle job start pulse.
REQ-008 SHALL have port i_abort  input  1  job cancel.
REQ-009 SHALL have port i_mode  input  2  job mode: 0 dual, 1 same-buffer, 2 square, 3 is treated as dual.
REQ-010 SHALL have port i_base_a  input  ADDR_W+1  operand A start address; MSB is the buffer select.
REQ-011 SHALL have port i_base_b  input  ADDR_W+1  operand B start address; MSB is the buffer select.
REQ-012 SHALL have port i_len  input  LEN_W  elements per vector.
REQ-013 SHALL have port i_rows  input  ROW_W  vectors per job.
REQ-014 SHALL have port i_stride_a  input  STRIDE_W  A row-to-row address step.
REQ-015 SHALL have port i_stride_b  input  STRIDE_W  B row-to-row address step.
REQ-016 SHALL have port o_busy  output  1  job in progress.
REQ-017 SHALL have port o_done  output  1  one-cycle job-complete pulse.
REQ-018 SHALL have ports o_ren0/o_raddr0  output  1/ADDR_W  buffer-0 read enable/address.
REQ-019 SHALL have ports o_ren1/o_raddr1  output  1/ADDR_W  buffer-1 read enable/address.
REQ-020 SHALL have port o_pe_valid  output  1  operand pair present at PE.
REQ-021 SHALL have port o_pe_last  output  1  qualifies o_pe_valid as last element of a row.

Function
REQ-022 SHALL latch all job inputs on i_start while in IDLE; SHALL ignore i_start in every other state.
REQ-023 SHALL implement states IDLE, RUN, PHASE_B, DONE.
- IDLE->RUN on start.
- IDLE->DONE if i_len==0 or i_rows==0.
REQ-024 SHALL resolve the effective mode at start as follows.
- Dual with both base MSBs equal -> same-buffer.
- Dual with different MSBs -> dual.
- Square -> square.
REQ-025 SHALL, in dual mode, issue one A read and one B read per RUN cycle, each on the port given by its base MSB; one element per cycle.
REQ-026 SHALL, in same-buffer mode, issue A in RUN and B in PHASE_B on the port given by the MSBs; RUN->PHASE_B->RUN; two cycles per element.
REQ-027 SHALL, in square mode, issue the A read only, one element per cycle; the B port enable SHALL stay 0.
REQ-028 SHALL drive an unused port with enable 0 and address 0.
REQ-029 SHALL increment element addresses by 1 modulo 2^ADDR_W within a row.
REQ-030 SHALL, at row end, compute the next row start as previous row start + stride (zero-extended) modulo 2^ADDR_W; the buffer-select MSB SHALL never change.
REQ-031 SHALL assert o_pe_valid exactly one cycle after the read cycle that completes an element (A in square and dual modes, B in same-buffer mode).
REQ-032 SHALL assert o_pe_last with o_pe_valid for element i_len-1 of each row.
REQ-033 SHALL go RUN/PHASE_B->DONE after the final read of the final row; DONE lasts one cycle, asserts o_done (coincident with the final o_pe_valid), then returns to IDLE.
REQ-034 SHALL assert o_busy in RUN, PHASE_B and DONE.
REQ-035 SHALL register all outputs from state and counters, with no combinational path from any input; the first read occurs one cycle after i_start.
REQ-036 SHALL, on i_abort in any state, go to IDLE the next cycle, with no o_done and no further o_pe_valid; i_abort SHALL take priority over a simultaneous i_start.

Reset
REQ-037 SHALL, on i_rst_n low, asynchronously force IDLE with all outputs and counters 0; reset mid-job SHALL discard the job with no o_done.

Verification
REQ-038 SHALL cover dual: base_a=0x000, base_b=0x1010, len=3, rows=1, start@0.
- Cycles 1-3: ren0=ren1=1, raddr0=0,1,2, raddr1=0x10,0x11,0x12.
- pe_valid cycles 2-4; pe_last@4; done@4.
REQ-039 SHALL cover same-buffer: base_a=0x005, base_b=0x020, len=2.
- ren0 cycles 1-4, addresses 5,0x20,6,0x21; ren1=0.
- pe_valid@3,5; done@5.
REQ-040 SHALL cover square with rows: base_a=0x1FFE, len=2, rows=2, stride_a=4.
- ren1 addresses 0xFFE, 0xFFF, 0x002, 0x003 (wrap); ren0=0.
- pe_last@3,5.
REQ-041 SHALL cover i_len=0 start -> no read enables, o_done@1, o_pe_valid never 1.
REQ-042 SHALL cover i_abort@2 of a len=8 dual job.
- Enables 0 from cycle 3; no o_done.
- A new i_start@3 is accepted, with its first read @4.
REQ-043 SHALL cover i_start asserted while busy -> ignored, address sequence unchanged; i_rst_n low mid-job -> all outputs 0 immediately.
